// File: rtl/sys_writeback.sv
// sys_writeback: drains one tile of systolic-array results into two byte-packed
// SRAM banks. Each row is requantized (rounding right shift, optional ReLU,
// saturation to int8). Rows flow through a two-stage pipeline that a stall
// input can freeze at any point.
module sys_writeback #(
    parameter int ARRAY_SIZE    = 8,
    parameter int OUTCOME_WIDTH = 21,
    parameter int ADDR_WIDTH    = 10,
    parameter int NUM_IDX       = 16
) (
    input  logic                                  clk,
    input  logic                                  srstn,
    input  logic                                  wb_start,
    input  logic                                  wb_hold,
    input  logic [ADDR_WIDTH-1:0]                 base_addr,
    input  logic [4:0]                            shift_amt,
    input  logic                                  relu_en,
    input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0]   mul_outcome,
    output logic [5:0]                            matrix_index,
    output logic                                  sram_wen,
    output logic [ADDR_WIDTH-1:0]                 sram_waddr,
    output logic [31:0]                           sram_wdata0,
    output logic [31:0]                           sram_wdata1,
    output logic                                  busy,
    output logic                                  done
);

    localparam int W          = OUTCOME_WIDTH;
    localparam int PACK_LANES = (ARRAY_SIZE < 8) ? ARRAY_SIZE : 8;
    localparam logic [5:0] LAST_IDX = 6'(NUM_IDX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state;
    logic                      flush_cnt;

    // Tile parameters captured when a start is accepted.
    logic [ADDR_WIDTH-1:0]     base_q;
    logic [4:0]                shift_q;
    logic                      relu_q;

    // Stage 1: raw row captured alongside its row index.
    logic                      s1_valid;
    logic [5:0]                s1_tag;
    logic [ARRAY_SIZE*W-1:0]   s1_data;

    // Stage 2 write-enable before the stall mask.
    logic                      wen_q;

    logic [7:0]                lane_byte [8];

    // Requantize one lane: round-half-up arithmetic right shift carried out
    // one bit wider than the accumulator so the rounding add cannot overflow,
    // then optional ReLU and saturation into a signed byte.
    function automatic logic [7:0] requant(
        input logic [W-1:0] x,
        input logic [4:0]   s,
        input logic         relu
    );
        logic signed [W:0] ext;
        logic signed [W:0] rnd;
        logic signed [W:0] v;
        logic        [W:0] half;
        logic        [4:0] se;
        logic        [7:0] res;
        se   = (s > 5'd20) ? 5'd20 : s;
        ext  = $signed({x[W-1], x});
        half = '0;
        rnd  = '0;
        if (se == 5'd0) begin
            v = ext;
        end else begin
            half = (W+1)'(1) << (se - 5'd1);
            rnd  = ext + $signed(half);
            v    = rnd >>> se;
        end
        if (relu && v[W]) begin
            res = 8'h00;
        end else if (v > $signed((W+1)'(127))) begin
            res = 8'h7F;
        end else if (v < $signed((W+1)'(-128))) begin
            res = 8'h80;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

    // Sequence the tile: accept a start, walk the row index, wait for the
    // pipeline to drain, then pulse done for exactly one cycle.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state        <= IDLE;
            matrix_index <= 6'd0;
            flush_cnt    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            base_q       <= '0;
            shift_q      <= 5'd0;
            relu_q       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_start) begin
                        state        <= RUN;
                        matrix_index <= 6'd0;
                        busy         <= 1'b1;
                        base_q       <= base_addr;
                        shift_q      <= shift_amt;
                        relu_q       <= relu_en;
                    end
                end
                RUN: begin
                    if (!wb_hold) begin
                        if (matrix_index == LAST_IDX) begin
                            state        <= FLUSH;
                            matrix_index <= 6'd0;
                            flush_cnt    <= 1'b0;
                        end else begin
                            matrix_index <= matrix_index + 6'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (!wb_hold) begin
                        if (flush_cnt) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            flush_cnt <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    matrix_index <= 6'd0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture the row the array is presenting for the current index.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            s1_valid <= 1'b0;
            s1_tag   <= 6'd0;
            s1_data  <= '0;
        end else if (!wb_hold) begin
            s1_valid <= (state == RUN);
            if (state == RUN) begin
                s1_tag  <= matrix_index;
                s1_data <= mul_outcome;
            end
        end
    end

    // Requantize every lane of the stage-1 row; lanes beyond eight are not packed.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            lane_byte[k] = 8'h00;
        end
        for (int k = 0; k < PACK_LANES; k++) begin
            lane_byte[k] = requant(s1_data[k*W +: W], shift_q, relu_q);
        end
    end

    // Stage 2: register the packed bytes and the wrapped write address.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            wen_q       <= 1'b0;
            sram_waddr  <= '0;
            sram_wdata0 <= 32'd0;
            sram_wdata1 <= 32'd0;
        end else if (!wb_hold) begin
            wen_q <= s1_valid;
            if (s1_valid) begin
                sram_waddr  <= base_q + ADDR_WIDTH'(s1_tag);
                sram_wdata0 <= {lane_byte[0], lane_byte[1], lane_byte[2], lane_byte[3]};
                sram_wdata1 <= {lane_byte[4], lane_byte[5], lane_byte[6], lane_byte[7]};
            end
        end
    end

    // A stalled cycle must not write; the frozen row is written once the stall lifts.
    assign sram_wen = wen_q & ~wb_hold;

endmodule

// File: tb/tb_sys_writeback.sv
// tb_sys_writeback: table-driven tiles with a write scoreboard, plus stall,
// stall-in-DONE, ignored-restart and mid-tile reset sequences.
module tb_sys_writeback;

    typedef logic [7:0][20:0] lanes_t;

    typedef struct packed {
        logic [9:0]  base;
        logic [4:0]  shift;
        logic        relu;
        lanes_t      lo;
        lanes_t      hi;
        logic [31:0] exp_lo0;
        logic [31:0] exp_lo1;
        logic [31:0] exp_hi0;
        logic [31:0] exp_hi1;
    } vec_t;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] d0;
        logic [31:0] d1;
    } wr_t;

    logic          clk;
    logic          srstn;
    logic          wb_start;
    logic          wb_hold;
    logic [9:0]    base_addr;
    logic [4:0]    shift_amt;
    logic          relu_en;
    logic [167:0]  mul_outcome;
    logic [5:0]    matrix_index;
    logic          sram_wen;
    logic [9:0]    sram_waddr;
    logic [31:0]   sram_wdata0;
    logic [31:0]   sram_wdata1;
    logic          busy;
    logic          done;

    lanes_t        cur_lo;
    lanes_t        cur_hi;

    int            checks;
    int            errors;
    int            cycle;
    int            last_write_cycle;
    int            write_count;
    logic          prev_done;
    wr_t           exp_q [$];
    vec_t          vecs [8];

    sys_writeback #(
        .ARRAY_SIZE    (8),
        .OUTCOME_WIDTH (21),
        .ADDR_WIDTH    (10),
        .NUM_IDX       (16)
    ) dut (
        .clk          (clk),
        .srstn        (srstn),
        .wb_start     (wb_start),
        .wb_hold      (wb_hold),
        .base_addr    (base_addr),
        .shift_amt    (shift_amt),
        .relu_en      (relu_en),
        .mul_outcome  (mul_outcome),
        .matrix_index (matrix_index),
        .sram_wen     (sram_wen),
        .sram_waddr   (sram_waddr),
        .sram_wdata0  (sram_wdata0),
        .sram_wdata1  (sram_wdata1),
        .busy         (busy),
        .done         (done)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Systolic array stand-in: rows 0..7 present cur_lo, rows 8..15 cur_hi.
    always_comb mul_outcome = (matrix_index < 6'd8) ? cur_lo : cur_hi;

    function automatic lanes_t mk_lanes(int a0, int a1, int a2, int a3,
                                        int a4, int a5, int a6, int a7);
        lanes_t r;
        r[0] = 21'(a0); r[1] = 21'(a1); r[2] = 21'(a2); r[3] = 21'(a3);
        r[4] = 21'(a4); r[5] = 21'(a5); r[6] = 21'(a6); r[7] = 21'(a7);
        return r;
    endfunction

    function automatic lanes_t rand_lanes();
        lanes_t r;
        for (int k = 0; k < 8; k++) r[k] = 21'($urandom_range(0, 2097151));
        return r;
    endfunction

    // Reference requantizer written as floor division on wide integers.
    function automatic logic [7:0] ref_byte(int x, int s, bit r);
        int     se;
        longint num, d, q;
        logic [7:0] b;
        se = (s > 20) ? 20 : s;
        if (se == 0) begin
            q = longint'(x);
        end else begin
            d   = longint'(1) << se;
            num = longint'(x) + d / 2;
            q   = num / d;
            if ((num % d) != 0 && num < 0) q = q - 1;
        end
        if (r && q < 0) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        b = q[7:0];
        return b;
    endfunction

    function automatic logic [31:0] exp_word(lanes_t l, int s, bit r, int first);
        logic [31:0] w;
        w = 32'd0;
        for (int j = 0; j < 4; j++) w = {w[23:0], ref_byte(int'($signed(l[first+j])), s, r)};
        return w;
    endfunction

    function automatic vec_t make_vec(logic [9:0] b, logic [4:0] s, logic r,
                                      lanes_t lo, lanes_t hi,
                                      logic [31:0] el0, logic [31:0] el1,
                                      logic [31:0] eh0, logic [31:0] eh1);
        vec_t v;
        v.base = b; v.shift = s; v.relu = r; v.lo = lo; v.hi = hi;
        v.exp_lo0 = el0; v.exp_lo1 = el1; v.exp_hi0 = eh0; v.exp_hi1 = eh1;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.base  = 10'($urandom_range(0, 1023));
        v.shift = 5'($urandom_range(0, 23));
        v.relu  = 1'($urandom_range(0, 1));
        v.lo    = rand_lanes();
        v.hi    = rand_lanes();
        v.exp_lo0 = exp_word(v.lo, int'(v.shift), v.relu, 0);
        v.exp_lo1 = exp_word(v.lo, int'(v.shift), v.relu, 4);
        v.exp_hi0 = exp_word(v.hi, int'(v.shift), v.relu, 0);
        v.exp_hi1 = exp_word(v.hi, int'(v.shift), v.relu, 4);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Write monitor: scoreboard pops, no write under stall, done timing, busy drop.
    always @(negedge clk) begin
        #1;
        cycle++;
        if (wb_hold) begin
            checks++;
            if (sram_wen) begin
                errors++;
                $display("[TB] FAIL wen_during_hold: got wen=1, expected 0 at cycle %0d", cycle);
            end
        end
        if (sram_wen) begin
            write_count++;
            last_write_cycle = cycle;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h_%0h, expected no write",
                         sram_waddr, sram_wdata0, sram_wdata1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (sram_waddr !== e.addr || sram_wdata0 !== e.d0 || sram_wdata1 !== e.d1) begin
                    errors++;
                    $display("[TB] FAIL write: got addr 0x%0h data 0x%0h_%0h, expected addr 0x%0h data 0x%0h_%0h",
                             sram_waddr, sram_wdata0, sram_wdata1, e.addr, e.d0, e.d1);
                end
            end
        end
        if (prev_done) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_after_done: got %b, expected 0", busy);
            end
        end
        if (done) begin
            checks++;
            if (cycle != last_write_cycle + 1) begin
                errors++;
                $display("[TB] FAIL done_timing: got done at cycle %0d, expected %0d",
                         cycle, last_write_cycle + 1);
            end
        end
        prev_done = done;
    end

    // Run one tile from vector vi with optional stall, ignored restart,
    // mid-tile reset and stall during DONE. Starts and ends on a negedge.
    task automatic applyStimulus(input int vi, input int hold_at, input int hold_len,
                                 input int restart_at, input int reset_at,
                                 input bit hold_in_done);
        vec_t v;
        wr_t  e;
        int   nrows, n, w0, hold_cnt;
        bit   finished, hold_started, restarted, start_clear, was_reset;
        v = vecs[vi];
        cur_lo    = v.lo;
        cur_hi    = v.hi;
        base_addr = v.base;
        shift_amt = v.shift;
        relu_en   = v.relu;
        nrows = (reset_at >= 0) ? reset_at - 1 : 16;
        for (int k = 0; k < nrows; k++) begin
            e.addr = v.base + 10'(k);
            e.d0   = (k < 8) ? v.exp_lo0 : v.exp_hi0;
            e.d1   = (k < 8) ? v.exp_lo1 : v.exp_hi1;
            exp_q.push_back(e);
        end
        w0 = write_count;
        wb_start = 1'b1;
        @(negedge clk);
        wb_start  = 1'b0;
        base_addr = ~v.base;
        shift_amt = 5'd7;
        relu_en   = ~v.relu;
        n = 1;
        finished = 0; hold_started = 0; restarted = 0; start_clear = 0; was_reset = 0;
        hold_cnt = 0;
        while (!finished && n < 100) begin
            if (reset_at >= 0 && busy && matrix_index == 6'(reset_at)) begin
                srstn = 1'b0;
                @(negedge clk);
                @(negedge clk);
                srstn = 1'b1;
                was_reset = 1;
                finished = 1;
            end else if (done) begin
                finished = 1;
            end else begin
                if (start_clear) begin
                    wb_start = 1'b0;
                    start_clear = 0;
                end
                if (restart_at >= 0 && !restarted && matrix_index == 6'(restart_at)) begin
                    wb_start  = 1'b1;
                    base_addr = 10'h2AA;
                    restarted = 1;
                    start_clear = 1;
                end
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    if (hold_cnt == 0) wb_hold = 1'b0;
                end else if (hold_len > 0 && !hold_started && matrix_index == 6'(hold_at)) begin
                    wb_hold = 1'b1;
                    hold_cnt = hold_len;
                    hold_started = 1;
                end
                @(negedge clk);
                n++;
            end
        end
        wb_start = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", n);
            wb_hold = 1'b0;
        end else if (was_reset) begin
            checkOutput("rst_matrix_index", 32'(matrix_index), 32'd0);
            checkOutput("rst_wen",          32'(sram_wen),     32'd0);
            checkOutput("rst_waddr",        32'(sram_waddr),   32'd0);
            checkOutput("rst_wdata0",       sram_wdata0,       32'd0);
            checkOutput("rst_wdata1",       sram_wdata1,       32'd0);
            checkOutput("rst_busy",         32'(busy),         32'd0);
            repeat (30) @(negedge clk);
            checkOutput("rst_busy_later",   32'(busy),         32'd0);
        end else begin
            checkOutput("done_latency", 32'(n), 32'(19 + hold_len));
            if (hold_in_done) begin
                wb_hold = 1'b1;
                @(negedge clk);
                checkOutput("hold_in_done_done", 32'(done), 32'd0);
                checkOutput("hold_in_done_busy", 32'(busy), 32'd0);
                wb_hold = 1'b0;
            end
            repeat (3) @(negedge clk);
        end
        checkOutput("write_count", 32'(write_count - w0), 32'(nrows));
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        checks = 0; errors = 0; cycle = 0; last_write_cycle = -10;
        write_count = 0; prev_done = 1'b0;
        srstn = 1'b0; wb_start = 1'b0; wb_hold = 1'b0;
        base_addr = 10'h0; shift_amt = 5'd0; relu_en = 1'b0;
        cur_lo = '0; cur_hi = '0;

        vecs[0] = make_vec(10'h040, 5'd0, 1'b0,
                           mk_lanes(-3, -2, -1, 0, 1, 2, 3, 4),
                           mk_lanes(-3, -2, -1, 0, 1, 2, 3, 4),
                           32'hFDFEFF00, 32'h01020304, 32'hFDFEFF00, 32'h01020304);
        vecs[1] = make_vec(10'h120, 5'd4, 1'b0,
                           mk_lanes(23, 24, -24, -25, 2047, -2049, 7, 8),
                           mk_lanes(23, 24, -24, -25, 2047, -2049, 7, 8),
                           32'h0102FFFE, 32'h7F800001, 32'h0102FFFE, 32'h7F800001);
        vecs[2] = make_vec(10'h100, 5'd0, 1'b1,
                           mk_lanes(-1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000),
                           mk_lanes(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000),
                           32'h00000000, 32'h00000000, 32'h7F7F7F7F, 32'h7F7F7F7F);
        vecs[3] = make_vec(10'h3F8, 5'd0, 1'b0,
                           mk_lanes(0, -128, 127, 128, -129, -1, 64, -64),
                           mk_lanes(0, -128, 127, 128, -129, -1, 64, -64),
                           32'h00807F7F, 32'h80FF40C0, 32'h00807F7F, 32'h80FF40C0);
        vecs[4] = make_vec(10'h200, 5'd31, 1'b0,
                           mk_lanes(1048575, -1048576, 524288, 524287, -524288, -524289, 0, 100),
                           mk_lanes(1048575, -1048576, 524288, 524287, -524288, -524289, 0, 100),
                           32'h01FF0100, 32'h00FF0000, 32'h01FF0100, 32'h00FF0000);
        vecs[5] = make_vec(10'h010, 5'd1, 1'b1,
                           mk_lanes(1, 2, 3, -1, -2, -3, 255, 256),
                           mk_lanes(1, 2, 3, -1, -2, -3, 255, 256),
                           32'h01010200, 32'h00007F7F, 32'h01010200, 32'h00007F7F);
        vecs[6] = rand_vec();
        vecs[7] = rand_vec();

        repeat (3) @(negedge clk);
        checkOutput("reset_matrix_index", 32'(matrix_index), 32'd0);
        checkOutput("reset_wen",          32'(sram_wen),     32'd0);
        checkOutput("reset_waddr",        32'(sram_waddr),   32'd0);
        checkOutput("reset_wdata0",       sram_wdata0,       32'd0);
        checkOutput("reset_wdata1",       sram_wdata1,       32'd0);
        checkOutput("reset_busy",         32'(busy),         32'd0);
        checkOutput("reset_done",         32'(done),         32'd0);
        srstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] tile from vector %0d", i);
            applyStimulus(i, -1, 0, -1, -1, 1'b0);
        end
        $display("[TB] stall of 3 cycles at index 5");
        applyStimulus(6, 5, 3, -1, -1, 1'b0);
        $display("[TB] ignored restart then reset at index 9");
        applyStimulus(7, -1, 0, 3, 9, 1'b0);
        $display("[TB] recovery tile with stall during DONE");
        applyStimulus(0, -1, 0, -1, -1, 1'b1);
        $display("[TB] stalled tile with wrapping addresses");
        applyStimulus(3, 5, 3, -1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
